// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C transaction sequencer: FSM state encoding and the
// i2c_master command word, plus constructors for the command variants used.
package i2c_seq_pkg;

  localparam int unsigned LEN_W_DEF = 4;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned DATA_W    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_WR,
    S_DATA_WR,
    S_CMD_RD,
    S_RD_BYTE,
    S_WAIT_IDLE,
    S_DONE,
    S_ABORT
  } seq_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              start;
    logic              read;
    logic              write;
    logic              write_multiple;
    logic              stop;
  } i2c_cmd_t;

  function automatic i2c_cmd_t cmd_write(input logic [ADDR_W-1:0] addr, input logic stop);
    i2c_cmd_t c;
    c                = '0;
    c.addr           = addr;
    c.start          = 1'b1;
    c.write_multiple = 1'b1;
    c.stop           = stop;
    return c;
  endfunction

  function automatic i2c_cmd_t cmd_read(input logic [ADDR_W-1:0] addr, input logic start,
                                        input logic stop);
    i2c_cmd_t c;
    c       = '0;
    c.addr  = addr;
    c.start = start;
    c.read  = 1'b1;
    c.stop  = stop;
    return c;
  endfunction

  function automatic i2c_cmd_t cmd_stop_only();
    i2c_cmd_t c;
    c      = '0;
    c.stop = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/i2c_seq_timeout.sv
// Handshake watchdog: reloads on clear, counts down while enabled, and flags
// expiry when it reaches zero. TIMEOUT_CYC of 0 disables it.
module i2c_seq_timeout #(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= LOAD;
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired_c = (TIMEOUT_CYC != 0) && (cnt == '0);

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Drives one i2c_master from a transaction descriptor: issues command words,
// frames the write stream, splits reads into per-byte commands, reports status.
module i2c_txn_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int unsigned LEN_W       = LEN_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [6:0]        desc_addr,
  input  logic              desc_read,
  input  logic [LEN_W-1:0]  desc_len,
  input  logic              desc_stop,
  input  logic [7:0]        wr_tdata,
  input  logic              wr_tvalid,
  output logic              wr_tready,
  output logic [7:0]        rd_tdata,
  output logic              rd_tvalid,
  output logic              rd_tlast,
  input  logic              rd_tready,
  output logic [6:0]        m_cmd_address,
  output logic              m_cmd_start,
  output logic              m_cmd_read,
  output logic              m_cmd_write,
  output logic              m_cmd_write_multiple,
  output logic              m_cmd_stop,
  output logic              m_cmd_valid,
  input  logic              m_cmd_ready,
  output logic [7:0]        m_data_tdata,
  output logic              m_data_tvalid,
  output logic              m_data_tlast,
  input  logic              m_data_tready,
  input  logic [7:0]        s_rd_tdata,
  input  logic              s_rd_tvalid,
  input  logic              s_rd_tlast,
  output logic              s_rd_tready,
  input  logic              m_busy,
  input  logic              m_missed_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  byte_count
);

  seq_state_t        state;
  i2c_cmd_t          cmd_q;
  logic [6:0]        addr_q;
  logic              stop_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic              err_q;

  logic in_wr, in_rd, last_c, next_last_c;
  logic cmd_hs, data_hs, rd_hs, wait_st;
  logic tmo_clear, tmo_expired;
  logic unused_rd_tlast;

  // The sequencer owns tlast on both streams; the master's own read tlast is not needed.
  assign unused_rd_tlast = s_rd_tlast;

  assign in_wr       = (state == S_DATA_WR);
  assign in_rd       = (state == S_RD_BYTE);
  assign last_c      = (idx_q == LEN_W'(len_q - LEN_W'(1)));
  assign next_last_c = (LEN_W'(idx_q + LEN_W'(1)) == LEN_W'(len_q - LEN_W'(1)));

  // Stream passthrough, gated so every stream output is idle outside its data phase.
  assign wr_tready     = in_wr & m_data_tready;
  assign m_data_tvalid = in_wr & wr_tvalid;
  assign m_data_tdata  = in_wr ? wr_tdata : '0;
  assign m_data_tlast  = in_wr & last_c;

  assign s_rd_tready   = in_rd & rd_tready;
  assign rd_tvalid     = in_rd & s_rd_tvalid;
  assign rd_tdata      = in_rd ? s_rd_tdata : '0;
  assign rd_tlast      = in_rd & last_c;

  assign m_cmd_address        = cmd_q.addr;
  assign m_cmd_start          = cmd_q.start;
  assign m_cmd_read           = cmd_q.read;
  assign m_cmd_write          = cmd_q.write;
  assign m_cmd_write_multiple = cmd_q.write_multiple;
  assign m_cmd_stop           = cmd_q.stop;

  assign cmd_hs  = m_cmd_valid & m_cmd_ready;
  assign data_hs = m_data_tvalid & m_data_tready;
  assign rd_hs   = rd_tvalid & rd_tready;
  assign wait_st = (state == S_CMD_WR) || (state == S_DATA_WR) || (state == S_CMD_RD) ||
                   (state == S_RD_BYTE) || (state == S_WAIT_IDLE);

  // Any progress restarts the watchdog; it only runs while waiting on the master.
  assign tmo_clear = !wait_st | cmd_hs | data_hs | rd_hs;

  i2c_seq_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear     (tmo_clear),
    .enable    (wait_st),
    .expired_c (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_q       <= '0;
      m_cmd_valid <= 1'b0;
      addr_q      <= '0;
      stop_q      <= 1'b0;
      len_q       <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      desc_ready  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      byte_count  <= '0;
    end else begin
      if ((state != S_IDLE) && m_missed_ack) err_q <= 1'b1;

      case (state)
        S_IDLE: begin
          if (desc_valid && desc_ready) begin
            addr_q     <= desc_addr;
            len_q      <= desc_len;
            idx_q      <= '0;
            err_q      <= 1'b0;
            desc_ready <= 1'b0;
            busy       <= 1'b1;
            if (desc_len == '0) begin
              // Illegal length: no bus traffic, finish through a no-wait WAIT_IDLE.
              err_q  <= 1'b1;
              stop_q <= 1'b0;
              state  <= S_WAIT_IDLE;
            end else if (desc_read) begin
              stop_q      <= desc_stop;
              cmd_q       <= cmd_read(desc_addr, 1'b1, desc_stop && (desc_len == LEN_W'(1)));
              m_cmd_valid <= 1'b1;
              state       <= S_CMD_RD;
            end else begin
              stop_q      <= desc_stop;
              cmd_q       <= cmd_write(desc_addr, desc_stop);
              m_cmd_valid <= 1'b1;
              state       <= S_CMD_WR;
            end
          end
        end

        S_CMD_WR, S_CMD_RD: begin
          if (cmd_hs) begin
            m_cmd_valid <= 1'b0;
            cmd_q       <= '0;
            state       <= (state == S_CMD_WR) ? S_DATA_WR : S_RD_BYTE;
          end else if (tmo_expired) begin
            m_cmd_valid <= 1'b0;
            cmd_q       <= '0;
            err_q       <= 1'b1;
            state       <= S_ABORT;
          end
        end

        S_DATA_WR: begin
          if (data_hs) begin
            idx_q <= idx_q + LEN_W'(1);
            if (last_c) state <= S_WAIT_IDLE;
          end else if (tmo_expired) begin
            err_q <= 1'b1;
            state <= S_ABORT;
          end
        end

        S_RD_BYTE: begin
          if (rd_hs) begin
            idx_q <= idx_q + LEN_W'(1);
            if (last_c) begin
              state <= S_WAIT_IDLE;
            end else begin
              cmd_q       <= cmd_read(addr_q, 1'b0, stop_q && next_last_c);
              m_cmd_valid <= 1'b1;
              state       <= S_CMD_RD;
            end
          end else if (tmo_expired) begin
            err_q <= 1'b1;
            state <= S_ABORT;
          end
        end

        S_WAIT_IDLE: begin
          if (!stop_q || !m_busy) begin
            done       <= 1'b1;
            err        <= err_q | m_missed_ack;
            byte_count <= idx_q;
            state      <= S_DONE;
          end else if (tmo_expired) begin
            err_q <= 1'b1;
            state <= S_ABORT;
          end
        end

        // Stop-only command; presented one cycle after any prior command was withdrawn.
        S_ABORT: begin
          if (!m_cmd_valid) begin
            cmd_q       <= cmd_stop_only();
            m_cmd_valid <= 1'b1;
          end else if (m_cmd_ready) begin
            cmd_q       <= '0;
            m_cmd_valid <= 1'b0;
            done        <= 1'b1;
            err         <= 1'b1;
            byte_count  <= idx_q;
            state       <= S_DONE;
          end
        end

        S_DONE: begin
          done       <= 1'b0;
          err        <= 1'b0;
          byte_count <= '0;
          busy       <= 1'b0;
          err_q      <= 1'b0;
          desc_ready <= 1'b1;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer; the bench plays the i2c_master side.
module tb_i2c_txn_sequencer;

  localparam int unsigned LEN_W = 4;
  localparam int unsigned TMO   = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             desc_valid, desc_ready, desc_read, desc_stop;
  logic [6:0]       desc_addr;
  logic [LEN_W-1:0] desc_len;
  logic [7:0]       wr_tdata;
  logic             wr_tvalid, wr_tready;
  logic [7:0]       rd_tdata;
  logic             rd_tvalid, rd_tlast, rd_tready;
  logic [6:0]       m_cmd_address;
  logic             m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop;
  logic             m_cmd_valid, m_cmd_ready;
  logic [7:0]       m_data_tdata;
  logic             m_data_tvalid, m_data_tlast, m_data_tready;
  logic [7:0]       s_rd_tdata;
  logic             s_rd_tvalid, s_rd_tlast, s_rd_tready;
  logic             m_busy, m_missed_ack;
  logic             busy, done, err;
  logic [LEN_W-1:0] byte_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_txn_sequencer #(.LEN_W(LEN_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_addr(desc_addr),
    .desc_read(desc_read), .desc_len(desc_len), .desc_stop(desc_stop),
    .wr_tdata(wr_tdata), .wr_tvalid(wr_tvalid), .wr_tready(wr_tready),
    .rd_tdata(rd_tdata), .rd_tvalid(rd_tvalid), .rd_tlast(rd_tlast), .rd_tready(rd_tready),
    .m_cmd_address(m_cmd_address), .m_cmd_start(m_cmd_start), .m_cmd_read(m_cmd_read),
    .m_cmd_write(m_cmd_write), .m_cmd_write_multiple(m_cmd_write_multiple),
    .m_cmd_stop(m_cmd_stop), .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_data_tdata(m_data_tdata), .m_data_tvalid(m_data_tvalid), .m_data_tlast(m_data_tlast),
    .m_data_tready(m_data_tready),
    .s_rd_tdata(s_rd_tdata), .s_rd_tvalid(s_rd_tvalid), .s_rd_tlast(s_rd_tlast),
    .s_rd_tready(s_rd_tready),
    .m_busy(m_busy), .m_missed_ack(m_missed_ack),
    .busy(busy), .done(done), .err(err), .byte_count(byte_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] cmd_flags();
    return {m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop};
  endfunction

  task automatic send_desc(input logic [6:0] a, input logic rd, input logic [LEN_W-1:0] n,
                           input logic st);
    check("desc_ready_before", desc_ready, 1);
    desc_addr = a; desc_read = rd; desc_len = n; desc_stop = st; desc_valid = 1'b1;
    @(negedge clk);
    desc_valid = 1'b0;
  endtask

  task automatic expect_cmd(input string tag, input logic [6:0] a, input logic [4:0] flags);
    check({tag, "_valid"}, m_cmd_valid, 1);
    check({tag, "_addr"}, m_cmd_address, a);
    check({tag, "_flags"}, cmd_flags(), flags);
  endtask

  task automatic accept_cmd();
    m_cmd_ready = 1'b1;
    @(negedge clk);
    m_cmd_ready = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic e, input logic [LEN_W-1:0] cnt);
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    check({tag, "_done"}, done, 1);
    check({tag, "_err"}, err, e);
    check({tag, "_count"}, byte_count, cnt);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle_ready"}, desc_ready, 1);
  endtask

  task automatic write_byte(input string tag, input logic [7:0] b, input logic last);
    wr_tdata = b; wr_tvalid = 1'b1;
    #1;
    check({tag, "_tvalid"}, m_data_tvalid, 1);
    check({tag, "_tdata"}, m_data_tdata, b);
    check({tag, "_tlast"}, m_data_tlast, last);
    @(negedge clk);
    wr_tvalid = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1;
    desc_valid = 0; desc_addr = '0; desc_read = 0; desc_len = '0; desc_stop = 0;
    wr_tdata = '0; wr_tvalid = 0; rd_tready = 0;
    m_cmd_ready = 0; m_data_tready = 0;
    s_rd_tdata = '0; s_rd_tvalid = 0; s_rd_tlast = 0;
    m_busy = 0; m_missed_ack = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_desc_ready", desc_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cmd_valid", m_cmd_valid, 0);
    check("rst_count", byte_count, 0);

    // Write A1 B2 C3 to 0x22 with stop, master busy while the bytes go out
    send_desc(7'h22, 1'b0, 4'd3, 1'b1);
    check("wr_desc_ready_low", desc_ready, 0);
    check("wr_busy", busy, 1);
    expect_cmd("wr_cmd", 7'h22, 5'b10011);
    @(negedge clk);
    expect_cmd("wr_cmd_hold", 7'h22, 5'b10011);
    accept_cmd();
    check("wr_cmd_dropped", m_cmd_valid, 0);
    m_busy = 1'b1;
    m_data_tready = 1'b1;
    write_byte("wr_b0", 8'hA1, 1'b0);
    m_data_tready = 1'b0;
    wr_tvalid = 1'b1; wr_tdata = 8'hB2;
    #1;
    check("wr_backpressure", wr_tready, 0);
    @(negedge clk);
    m_data_tready = 1'b1;
    write_byte("wr_b1", 8'hB2, 1'b0);
    write_byte("wr_b2", 8'hC3, 1'b1);
    m_data_tready = 1'b0;
    repeat (3) @(negedge clk);
    check("wr_waits_busy", done, 0);
    m_busy = 1'b0;
    wait_done("wr", 1'b0, 4'd3);

    // Read 5A 3C from 0x22 with stop, host stalls 50 cycles on the last byte
    send_desc(7'h22, 1'b1, 4'd2, 1'b1);
    expect_cmd("rd_cmd0", 7'h22, 5'b11000);
    accept_cmd();
    s_rd_tdata = 8'h5A; s_rd_tvalid = 1'b1; s_rd_tlast = 1'b1; rd_tready = 1'b1;
    #1;
    check("rd_b0_tvalid", rd_tvalid, 1);
    check("rd_b0_tdata", rd_tdata, 8'h5A);
    check("rd_b0_tlast", rd_tlast, 0);
    check("rd_b0_sready", s_rd_tready, 1);
    @(negedge clk);
    s_rd_tvalid = 1'b0; rd_tready = 1'b0;
    expect_cmd("rd_cmd1", 7'h22, 5'b01001);
    accept_cmd();
    s_rd_tdata = 8'h3C; s_rd_tvalid = 1'b1; s_rd_tlast = 1'b0;
    repeat (50) @(negedge clk);
    check("rd_stall_sready", s_rd_tready, 0);
    check("rd_stall_tvalid", rd_tvalid, 1);
    check("rd_stall_tdata", rd_tdata, 8'h3C);
    check("rd_stall_no_done", done, 0);
    rd_tready = 1'b1;
    #1;
    check("rd_b1_tdata", rd_tdata, 8'h3C);
    check("rd_b1_tlast", rd_tlast, 1);
    @(negedge clk);
    s_rd_tvalid = 1'b0; rd_tready = 1'b0;
    wait_done("rd", 1'b0, 4'd2);

    // Single write to unmapped 0x11; master reports a missed ACK
    send_desc(7'h11, 1'b0, 4'd1, 1'b1);
    expect_cmd("nak_cmd", 7'h11, 5'b10011);
    accept_cmd();
    m_missed_ack = 1'b1;
    @(negedge clk);
    m_missed_ack = 1'b0;
    m_data_tready = 1'b1;
    write_byte("nak_b0", 8'h77, 1'b1);
    m_data_tready = 1'b0;
    wait_done("nak", 1'b1, 4'd1);

    // Zero length: error, no command
    send_desc(7'h22, 1'b0, 4'd0, 1'b1);
    check("len0_no_cmd", m_cmd_valid, 0);
    check("len0_not_yet", done, 0);
    @(negedge clk);
    check("len0_done", done, 1);
    check("len0_err", err, 1);
    check("len0_count", byte_count, 0);
    check("len0_no_cmd2", m_cmd_valid, 0);
    @(negedge clk);
    check("len0_ready", desc_ready, 1);

    // Command never accepted: watchdog aborts with a stop-only command
    send_desc(7'h22, 1'b0, 4'd2, 1'b1);
    expect_cmd("tmo_cmd", 7'h22, 5'b10011);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      n = i;
      if (m_cmd_valid && (cmd_flags() == 5'b00001)) break;
    end
    check("tmo_abort_cycle", n, 66);
    expect_cmd("tmo_stop_cmd", 7'h00, 5'b00001);
    @(negedge clk);
    check("tmo_waits_ready", done, 0);
    accept_cmd();
    check("tmo_done", done, 1);
    check("tmo_err", err, 1);
    check("tmo_count", byte_count, 0);
    @(negedge clk);

    // Reset in the middle of a write data phase
    send_desc(7'h22, 1'b0, 4'd2, 1'b1);
    accept_cmd();
    m_data_tready = 1'b1;
    write_byte("mid_b0", 8'h11, 1'b0);
    wr_tvalid = 1'b1; wr_tdata = 8'h22;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", desc_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr_tready", wr_tready, 0);
    check("mid_rst_m_tvalid", m_data_tvalid, 0);
    check("mid_rst_cmd_valid", m_cmd_valid, 0);
    rst = 1'b0; wr_tvalid = 1'b0; m_data_tready = 1'b0;
    @(negedge clk);
    check("post_rst_ready", desc_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
